vga_mem_arbiter: RTL and testbench
==================================

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, framebuffer word address width.
REQ-002 SHALL have parameter DATA_W, default 12, pixel word packed {red[3:0],green[3:0],blue[3:0]}.
REQ-003 SHALL have parameter STARVE_MAX, default 8, writer wait-cycle limit (1..255).
REQ-004 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port vblank, input, 1, high during vertical blanking.
REQ-007 SHALL have ports scan_req input 1, scan_addr input ADDR_W, scan_gnt output 1; scanout read requester.
REQ-008 SHALL have ports scan_rvalid output 1, scan_rdata output DATA_W; scanout read return.
REQ-009 SHALL have ports wr_req input 1, wr_addr input ADDR_W, wr_data input DATA_W, wr_gnt output 1; pixel writer.
REQ-010 SHALL have ports mem_en output 1, mem_we output 1, mem_addr output ADDR_W, mem_wdata output DATA_W, mem_rdata input DATA_W; single-port RAM with 1-cycle read latency.

Function
REQ-011 SHALL assert at most one of scan_gnt/wr_gnt per cycle; gnt is combinational from current req, vblank and registered state.
REQ-012 SHALL grant a requester only while its req is high; a request is consumed in the cycle its gnt is high; req held high next cycle is a new request.
REQ-013 Requester SHALL hold req, addr, data stable until gnt; arbiter SHALL NOT depend on values after the grant cycle.
REQ-014 Priority: vblank=0 -> scanout first; vblank=1 -> writer first; a lone requester is always granted (no idle cycle).
REQ-015 In the cycle after any grant, mem_en=1, mem_addr=granted addr, mem_we=1 for writer/0 for scanout, mem_wdata=wr_data for writes (held 0 for reads); otherwise mem_en=0, mem_we=0, addr/wdata hold last value.
REQ-016 scan_rvalid SHALL pulse exactly 2 cycles after scan_gnt, scan_rdata = mem_rdata registered; one rvalid per scan grant, in grant order.
REQ-017 Full throughput: back-to-back grants every cycle SHALL be supported, including alternating owners.
REQ-018 vblank edge takes effect the same cycle it changes (combinational priority), no extra latency.
REQ-019 scan_rdata SHALL hold its value when scan_rvalid=0.

Reset
REQ-020 rst_n low SHALL asynchronously force scan_gnt=0, wr_gnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, scan_rvalid=0, scan_rdata=0, starvation counter=0.
REQ-021 Reads in flight at reset SHALL be discarded (no rvalid after release); first grant possible in the first cycle rst_n is sampled high.

Configuration
REQ-022 Macro WR_STARVE_GUARD_EN SHALL, when defined, enable an 8-bit counter incrementing each cycle wr_req=1 and wr_gnt=0, cleared on wr_gnt or wr_req=0.
REQ-023 With WR_STARVE_GUARD_EN defined, when counter == STARVE_MAX the writer SHALL win the next contested cycle regardless of vblank, then counter clears.
REQ-024 Without WR_STARVE_GUARD_EN, no counter SHALL exist and priority is exactly REQ-014 (writer may starve indefinitely outside vblank).

Verification
REQ-025 vblank=0, scan_req and wr_req both high, one cycle -> scan_gnt=1, wr_gnt=0; next cycle mem_en=1, mem_we=0, mem_addr=scan_addr.
REQ-026 vblank=1, both req, wr_addr=0x00010, wr_data=0xF0A -> wr_gnt=1; next cycle mem_we=1, mem_addr=0x00010, mem_wdata=0xF0A.
REQ-027 scan_req high 4 cycles, addrs 0..3, mem_rdata=addr+0x100 -> scan_rvalid high 4 consecutive cycles starting 2 after first grant, data 0x100..0x103 in order.
REQ-028 WR_STARVE_GUARD_EN, STARVE_MAX=8, vblank=0, both req continuous -> 8 scan grants then 1 wr_gnt, pattern repeating; without macro -> wr_gnt never asserts.
REQ-029 rst_n low mid-stream with read pending -> all outputs 0 immediately, no scan_rvalid after rst_n returns high.

Source files
------------

// File: rtl/vga_mem_arbiter.sv
// Single-port framebuffer arbiter between VGA scanout reads and a pixel writer.
// Optional macro WR_STARVE_GUARD_EN adds a writer starvation guard counter.
module vga_mem_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 12,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vblank,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_gnt,
    output logic              scan_rvalid,
    output logic [DATA_W-1:0] scan_rdata,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
        $error("STARVE_MAX must lie in 1..255");
    end

    logic wr_first;
    logic rd_pend;

`ifdef WR_STARVE_GUARD_EN
    logic [7:0] starve_cnt;

    assign wr_first = vblank || (starve_cnt == 8'(STARVE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!wr_req || wr_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != '1) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`else
    assign wr_first = vblank;
`endif

    // Grants are gated by rst_n so they drop the instant reset asserts.
    always_comb begin
        scan_gnt = 1'b0;
        wr_gnt   = 1'b0;
        if (rst_n) begin
            if (wr_req && (wr_first || !scan_req)) begin
                wr_gnt = 1'b1;
            end else if (scan_req) begin
                scan_gnt = 1'b1;
            end
        end
    end

    // mem_rdata is valid in the mem_en cycle; it is captured at that cycle's end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rd_pend     <= 1'b0;
            scan_rvalid <= 1'b0;
            scan_rdata  <= '0;
        end else begin
            mem_en  <= scan_gnt | wr_gnt;
            mem_we  <= wr_gnt;
            rd_pend <= scan_gnt;
            if (wr_gnt) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else if (scan_gnt) begin
                mem_addr  <= scan_addr;
                mem_wdata <= '0;
            end
            scan_rvalid <= rd_pend;
            if (rd_pend) begin
                scan_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed self-checking bench for vga_mem_arbiter; memory returns addr+0x100.
module tb_vga_mem_arbiter;

    localparam int AW = 19;
    localparam int DW = 12;
`ifdef WR_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vblank;
    logic          scan_req;
    logic [AW-1:0] scan_addr;
    logic          scan_gnt;
    logic          scan_rvalid;
    logic [DW-1:0] scan_rdata;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign mem_rdata = DW'(mem_addr) + 12'h100;

    vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n), .vblank(vblank),
        .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(scan_gnt),
        .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_scan_gnt"}, 32'(scan_gnt), 0);
        chk({tag, "_wr_gnt"}, 32'(wr_gnt), 0);
        chk({tag, "_mem_en"}, 32'(mem_en), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_rvalid"}, 32'(scan_rvalid), 0);
        chk({tag, "_rdata"}, 32'(scan_rdata), 0);
    endtask

    initial begin
        logic exp_v;
        logic exp_s;
        logic exp_w;
        int   wr_seen;

        rst_n = 1'b0; vblank = 1'b0;
        scan_req = 1'b1; scan_addr = 19'h00003;
        wr_req = 1'b1; wr_addr = 19'h00004; wr_data = 12'h555;
        #3;
        chk_all_zero("reset");
        next_cycle();
        next_cycle();
        scan_req = 1'b0; wr_req = 1'b0;
        rst_n = 1'b1;
        next_cycle();

        // Contention outside vblank: scanout wins
        scan_req = 1'b1; scan_addr = 19'h12345;
        wr_req = 1'b1; wr_addr = 19'h00777; wr_data = 12'h123;
        #1;
        chk("r025_scan_gnt", 32'(scan_gnt), 1);
        chk("r025_wr_gnt", 32'(wr_gnt), 0);
        next_cycle();
        scan_req = 1'b0; wr_req = 1'b0;
        chk("r025_mem_en", 32'(mem_en), 1);
        chk("r025_mem_we", 32'(mem_we), 0);
        chk("r025_mem_addr", 32'(mem_addr), 32'h12345);
        chk("r025_mem_wdata", 32'(mem_wdata), 0);
        next_cycle();
        chk("r025_rvalid", 32'(scan_rvalid), 1);
        chk("r025_rdata", 32'(scan_rdata), 32'h445);
        chk("idle_mem_en", 32'(mem_en), 0);
        chk("idle_addr_hold", 32'(mem_addr), 32'h12345);
        next_cycle();
        chk("rvalid_single", 32'(scan_rvalid), 0);
        chk("rdata_hold", 32'(scan_rdata), 32'h445);

        // Contention in vblank: writer wins
        vblank = 1'b1;
        scan_req = 1'b1; scan_addr = 19'h00005;
        wr_req = 1'b1; wr_addr = 19'h00010; wr_data = 12'hF0A;
        #1;
        chk("r026_wr_gnt", 32'(wr_gnt), 1);
        chk("r026_scan_gnt", 32'(scan_gnt), 0);
        next_cycle();
        scan_req = 1'b0; wr_req = 1'b0;
        chk("r026_mem_en", 32'(mem_en), 1);
        chk("r026_mem_we", 32'(mem_we), 1);
        chk("r026_mem_addr", 32'(mem_addr), 32'h10);
        chk("r026_mem_wdata", 32'(mem_wdata), 32'hF0A);
        next_cycle();
        chk("wr_after_en", 32'(mem_en), 0);
        chk("wr_after_we", 32'(mem_we), 0);
        chk("wr_after_wdata_hold", 32'(mem_wdata), 32'hF0A);
        chk("wr_no_rvalid", 32'(scan_rvalid), 0);

        // Lone requesters and same-cycle vblank priority flips
        vblank = 1'b0; wr_req = 1'b1;
        #1 chk("lone_wr", 32'(wr_gnt), 1);
        wr_req = 1'b0; vblank = 1'b1; scan_req = 1'b1;
        #1 chk("lone_scan", 32'(scan_gnt), 1);
        wr_req = 1'b1; vblank = 1'b0;
        #1 chk("vb_edge_scan", 32'(scan_gnt), 1);
        vblank = 1'b1;
        #1 chk("vb_edge_wr", 32'(wr_gnt), 1);
        chk("vb_edge_one_hot", 32'(scan_gnt), 0);
        scan_req = 1'b0; wr_req = 1'b0; vblank = 1'b0;
        next_cycle();

        // Four back-to-back scan reads
        for (int k = 0; k < 8; k++) begin
            scan_req = (k < 4);
            scan_addr = AW'(k);
            #1;
            exp_v = (k >= 2 && k < 6);
            chk($sformatf("burst_gnt_%0d", k), 32'(scan_gnt), 32'(k < 4));
            chk($sformatf("burst_rvalid_%0d", k), 32'(scan_rvalid), 32'(exp_v));
            if (exp_v) chk($sformatf("burst_rdata_%0d", k), 32'(scan_rdata), 32'h100 + 32'(k - 2));
            next_cycle();
        end

        // Alternating owners every cycle
        for (int k = 0; k < 6; k++) begin
            scan_req = (k < 4); wr_req = (k < 4);
            vblank = k[0];
            scan_addr = AW'(32'h20 + k);
            wr_addr = AW'(32'h40 + k);
            wr_data = DW'(32'hA00 + k);
            #1;
            chk($sformatf("alt_scan_gnt_%0d", k), 32'(scan_gnt), 32'(k < 4 && !k[0]));
            chk($sformatf("alt_wr_gnt_%0d", k), 32'(wr_gnt), 32'(k < 4 && k[0]));
            if (k >= 1 && k <= 4) begin
                chk($sformatf("alt_mem_en_%0d", k), 32'(mem_en), 1);
                chk($sformatf("alt_mem_we_%0d", k), 32'(mem_we), 32'(!k[0]));
                chk($sformatf("alt_mem_addr_%0d", k), 32'(mem_addr),
                    (k[0] ? 32'h20 : 32'h40) + 32'(k - 1));
                if (!k[0]) chk($sformatf("alt_wdata_%0d", k), 32'(mem_wdata), 32'hA00 + 32'(k - 1));
            end
            chk($sformatf("alt_rvalid_%0d", k), 32'(scan_rvalid), 32'(k == 2 || k == 4));
            if (k == 2 || k == 4) chk($sformatf("alt_rdata_%0d", k), 32'(scan_rdata), 32'h120 + 32'(k - 2));
            next_cycle();
        end

        // Continuous contention outside vblank
        vblank = 1'b0; scan_req = 1'b1; wr_req = 1'b1;
        wr_seen = 0;
        for (int k = 0; k < 18; k++) begin
            #1;
            exp_w = GUARD && (k % 9 == 8);
            exp_s = !exp_w;
            chk($sformatf("starve_wr_%0d", k), 32'(wr_gnt), 32'(exp_w));
            chk($sformatf("starve_scan_%0d", k), 32'(scan_gnt), 32'(exp_s));
            if (wr_gnt) wr_seen++;
            next_cycle();
        end
        chk("starve_wr_total", 32'(wr_seen), GUARD ? 2 : 0);
        scan_req = 1'b0; wr_req = 1'b0;
        for (int k = 0; k < 3; k++) next_cycle();

        // Reset with a read in flight
        scan_req = 1'b1; scan_addr = 19'h00007;
        #1 chk("rst_pre_gnt", 32'(scan_gnt), 1);
        next_cycle();
        scan_req = 1'b0; wr_req = 1'b1;
        chk("rst_pre_mem_en", 32'(mem_en), 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        next_cycle();
        next_cycle();
        wr_req = 1'b0;
        #3 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            chk($sformatf("post_rst_rvalid_%0d", k), 32'(scan_rvalid), 0);
        end
        scan_req = 1'b1; scan_addr = 19'h00009;
        #1 chk("post_rst_first_gnt", 32'(scan_gnt), 1);
        next_cycle();
        scan_req = 1'b0;
        chk("post_rst_mem_addr", 32'(mem_addr), 32'h9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
